oq_regs_access_arb: RTL and testbench

//  Single-owner arbiter for the OQ per-queue register file access port. Shares the port between

---
 rtl/oq_regs_access_arb_pkg.sv | 30 +++
 rtl/oq_rr_pick3.sv | 31 +++
 rtl/oq_regs_access_arb.sv | 216 +++++++++++++++++++++
 tb/tb_oq_regs_access_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oq_regs_access_arb_pkg.sv
// rtl/oq_regs_access_arb_pkg.sv - state encodings, owner codes and abort data shared by the OQ register arbiter
package oq_regs_access_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWN_HOST = 2'd0;
  localparam logic [1:0] OWN_SRC  = 2'd1;
  localparam logic [1:0] OWN_DST  = 2'd2;

  localparam logic [31:0] OQ_ARB_ERR_DATA = 32'hdead_beef;

  // Bit order matches {dst, src, host} so the vector lines up with the request vector.
  function automatic logic [2:0] owner_onehot(input logic [1:0] owner);
    logic [2:0] oh;
    oh = 3'b000;
    case (owner)
      OWN_HOST: oh = 3'b001;
      OWN_SRC:  oh = 3'b010;
      OWN_DST:  oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/oq_rr_pick3.sv
// rtl/oq_rr_pick3.sv - combinational 3-way round-robin picker; priority starts just after the last grant
module oq_rr_pick3
  import oq_regs_access_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant
);

  always_comb begin
    grant = OWN_HOST;
    case (last)
      OWN_HOST: begin
        if (req[1])      grant = OWN_SRC;
        else if (req[2]) grant = OWN_DST;
        else             grant = OWN_HOST;
      end
      OWN_SRC: begin
        if (req[2])      grant = OWN_DST;
        else if (req[0]) grant = OWN_HOST;
        else             grant = OWN_SRC;
      end
      default: begin
        if (req[0])      grant = OWN_HOST;
        else if (req[1]) grant = OWN_SRC;
        else             grant = OWN_DST;
      end
    endcase
  end

endmodule

// File: rtl/oq_regs_access_arb.sv
// rtl/oq_regs_access_arb.sv - single-owner round-robin arbiter for the OQ per-queue register access port
// Optional WAIT watchdog enabled by defining OQ_ARB_TIMEOUT_EN.
module oq_regs_access_arb
  import oq_regs_access_arb_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int NUM_REGS_USED     = 17,
  parameter int ADDR_WIDTH        = $clog2(NUM_REGS_USED),
  parameter int DATA_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    host_req,
  input  logic                    host_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [NUM_OQ_WIDTH-1:0] host_q_addr,
  input  logic [DATA_WIDTH-1:0]   host_wr_data,
  output logic                    host_done,

  input  logic                    src_req,
  input  logic                    src_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [NUM_OQ_WIDTH-1:0] src_q_addr,
  input  logic [DATA_WIDTH-1:0]   src_wr_data,
  output logic                    src_done,

  input  logic                    dst_req,
  input  logic                    dst_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [NUM_OQ_WIDTH-1:0] dst_q_addr,
  input  logic [DATA_WIDTH-1:0]   dst_wr_data,
  output logic                    dst_done,

  output logic [DATA_WIDTH-1:0]   result,

  output logic                    acc_valid,
  output logic [1:0]              acc_src,
  output logic                    acc_rd_wr_L,
  output logic [ADDR_WIDTH-1:0]   acc_addr,
  output logic [NUM_OQ_WIDTH-1:0] acc_q_addr,
  output logic [DATA_WIDTH-1:0]   acc_wr_data,
  input  logic                    acc_done,
  input  logic [DATA_WIDTH-1:0]   acc_result,

  output logic                    timeout_err
);

  arb_state_t state, state_nxt;
  logic [1:0] rr_last, rr_last_nxt;
  logic [1:0] pick;
  logic [2:0] req_vec;
  logic       any_req;

  logic                    pick_rd_wr_L;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [NUM_OQ_WIDTH-1:0] pick_q_addr;
  logic [DATA_WIDTH-1:0]   pick_wr_data;

  logic                    acc_valid_nxt;
  logic [1:0]              acc_src_nxt;
  logic                    acc_rd_wr_L_nxt;
  logic [ADDR_WIDTH-1:0]   acc_addr_nxt;
  logic [NUM_OQ_WIDTH-1:0] acc_q_addr_nxt;
  logic [DATA_WIDTH-1:0]   acc_wr_data_nxt;
  logic [DATA_WIDTH-1:0]   result_nxt;
  logic [2:0]              done_vec, done_nxt;
  logic                    tmo_q, tmo_nxt;

`ifdef OQ_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0) ^ OQ_ARB_ERR_DATA[0];
`endif

  assign req_vec = {dst_req, src_req, host_req};
  assign any_req = |req_vec;

  oq_rr_pick3 u_pick (
    .req   (req_vec),
    .last  (rr_last),
    .grant (pick)
  );

  always_comb begin
    pick_rd_wr_L = host_rd_wr_L;
    pick_addr    = host_addr;
    pick_q_addr  = host_q_addr;
    pick_wr_data = host_wr_data;
    case (pick)
      OWN_SRC: begin
        pick_rd_wr_L = src_rd_wr_L;
        pick_addr    = src_addr;
        pick_q_addr  = src_q_addr;
        pick_wr_data = src_wr_data;
      end
      OWN_DST: begin
        pick_rd_wr_L = dst_rd_wr_L;
        pick_addr    = dst_addr;
        pick_q_addr  = dst_q_addr;
        pick_wr_data = dst_wr_data;
      end
      default: ;
    endcase
  end

  // Access fields are only reloaded on a grant so they stay visible after done.
  always_comb begin
    state_nxt       = state;
    rr_last_nxt     = rr_last;
    acc_valid_nxt   = 1'b0;
    acc_src_nxt     = acc_src;
    acc_rd_wr_L_nxt = acc_rd_wr_L;
    acc_addr_nxt    = acc_addr;
    acc_q_addr_nxt  = acc_q_addr;
    acc_wr_data_nxt = acc_wr_data;
    result_nxt      = result;
    done_nxt        = 3'b000;
    tmo_nxt         = 1'b0;
`ifdef OQ_ARB_TIMEOUT_EN
    wait_cnt_nxt    = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt       = ST_ISSUE;
          acc_valid_nxt   = 1'b1;
          acc_src_nxt     = pick;
          acc_rd_wr_L_nxt = pick_rd_wr_L;
          acc_addr_nxt    = pick_addr;
          acc_q_addr_nxt  = pick_q_addr;
          acc_wr_data_nxt = pick_wr_data;
        end
      end
      ST_ISSUE: begin
        state_nxt   = ST_WAIT;
        rr_last_nxt = acc_src;
`ifdef OQ_ARB_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ST_WAIT: begin
        if (acc_done) begin
          state_nxt  = ST_DONE;
          result_nxt = acc_result;
          done_nxt   = owner_onehot(acc_src);
        end
`ifdef OQ_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt  = ST_DONE;
          result_nxt = DATA_WIDTH'(OQ_ARB_ERR_DATA);
          done_nxt   = owner_onehot(acc_src);
          tmo_nxt    = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_last     <= OWN_DST;
      acc_valid   <= 1'b0;
      acc_src     <= 2'd0;
      acc_rd_wr_L <= 1'b0;
      acc_addr    <= '0;
      acc_q_addr  <= '0;
      acc_wr_data <= '0;
      result      <= '0;
      done_vec    <= 3'b000;
      tmo_q       <= 1'b0;
`ifdef OQ_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      rr_last     <= rr_last_nxt;
      acc_valid   <= acc_valid_nxt;
      acc_src     <= acc_src_nxt;
      acc_rd_wr_L <= acc_rd_wr_L_nxt;
      acc_addr    <= acc_addr_nxt;
      acc_q_addr  <= acc_q_addr_nxt;
      acc_wr_data <= acc_wr_data_nxt;
      result      <= result_nxt;
      done_vec    <= done_nxt;
      tmo_q       <= tmo_nxt;
`ifdef OQ_ARB_TIMEOUT_EN
      wait_cnt    <= wait_cnt_nxt;
`endif
    end
  end

  assign host_done = done_vec[0];
  assign src_done  = done_vec[1];
  assign dst_done  = done_vec[2];

`ifdef OQ_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
  logic unused_tmo_q;
  assign unused_tmo_q = tmo_q;
`endif

endmodule

// File: tb/tb_oq_regs_access_arb.sv
// tb/tb_oq_regs_access_arb.sv - directed table-driven bench for the OQ register access arbiter
module tb_oq_regs_access_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_req = 0, host_rd_wr_L = 0, src_req = 0, src_rd_wr_L = 0, dst_req = 0, dst_rd_wr_L = 0;
  logic [4:0]  host_addr = 0, src_addr = 0, dst_addr = 0;
  logic [2:0]  host_q_addr = 0, src_q_addr = 0, dst_q_addr = 0;
  logic [31:0] host_wr_data = 0, src_wr_data = 0, dst_wr_data = 0;
  logic        host_done, src_done, dst_done;
  logic [31:0] result;
  logic        acc_valid;
  logic [1:0]  acc_src;
  logic        acc_rd_wr_L;
  logic [4:0]  acc_addr;
  logic [2:0]  acc_q_addr;
  logic [31:0] acc_wr_data;
  logic        acc_done = 1'b0;
  logic [31:0] acc_result = 32'h0;
  logic        timeout_err;
  logic [2:0]  dones;

  int n_tests = 0;
  int n_fail  = 0;

  assign dones = {dst_done, src_done, host_done};

  always #5 clk = ~clk;

  oq_regs_access_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_rd_wr_L(host_rd_wr_L), .host_addr(host_addr),
    .host_q_addr(host_q_addr), .host_wr_data(host_wr_data), .host_done(host_done),
    .src_req(src_req), .src_rd_wr_L(src_rd_wr_L), .src_addr(src_addr),
    .src_q_addr(src_q_addr), .src_wr_data(src_wr_data), .src_done(src_done),
    .dst_req(dst_req), .dst_rd_wr_L(dst_rd_wr_L), .dst_addr(dst_addr),
    .dst_q_addr(dst_q_addr), .dst_wr_data(dst_wr_data), .dst_done(dst_done),
    .result(result), .acc_valid(acc_valid), .acc_src(acc_src), .acc_rd_wr_L(acc_rd_wr_L),
    .acc_addr(acc_addr), .acc_q_addr(acc_q_addr), .acc_wr_data(acc_wr_data),
    .acc_done(acc_done), .acc_result(acc_result), .timeout_err(timeout_err)
  );

  typedef struct {
    int          who;
    logic        rd_wr_L;
    logic [4:0]  addr;
    logic [2:0]  q_addr;
    logic [31:0] wr_data;
    int          dly;
    logic [31:0] res;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int who, input logic rw, input logic [4:0] a, input logic [2:0] q,
                         input logic [31:0] wd);
    case (who)
      0: begin host_rd_wr_L = rw; host_addr = a; host_q_addr = q; host_wr_data = wd; host_req = 1; end
      1: begin src_rd_wr_L = rw; src_addr = a; src_q_addr = q; src_wr_data = wd; src_req = 1; end
      default: begin dst_rd_wr_L = rw; dst_addr = a; dst_q_addr = q; dst_wr_data = wd; dst_req = 1; end
    endcase
  endtask

  task automatic drop_req(input int who);
    case (who)
      0: host_req = 0;
      1: src_req = 0;
      default: dst_req = 0;
    endcase
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    step();
    reset = 1;
    step();
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic serve(input string tag, input int own, input int dly, input logic [31:0] res,
                       input bit drop);
    step();
    check({tag, " acc_valid"}, acc_valid, 1);
    check({tag, " acc_src"}, acc_src, own);
    for (int i = 0; i < dly; i++) begin
      step();
      if (i == 0) check({tag, " acc_valid one cycle"}, acc_valid, 0);
      check({tag, " no early done"}, dones, 0);
      if (i == dly - 1) begin
        acc_done = 1;
        acc_result = res;
      end
    end
    step();
    acc_done = 0;
    check({tag, " done"}, dones, 32'd1 << own);
    check({tag, " result"}, result, res);
    step();
    if (drop) drop_req(own);
    check({tag, " done one cycle"}, dones, 0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 5'd5,  3'd3, 32'h0,         2, 32'h0000_1234, 2'd0};
    vecs[1] = '{1, 1'b0, 5'd16, 3'd7, 32'ha5a5_0001, 1, 32'hcafe_0001, 2'd1};
    vecs[2] = '{2, 1'b1, 5'd0,  3'd0, 32'h0,         3, 32'hffff_ffff, 2'd2};
    vecs[3] = '{0, 1'b0, 5'd10, 3'd5, 32'h0000_0001, 1, 32'h8000_0000, 2'd0};

    step();
    step();
    check("reset acc_valid", acc_valid, 0);
    check("reset dones", dones, 0);
    check("reset result", result, 0);
    check("reset timeout_err", timeout_err, 0);
    reset = 1;
    step();

    for (int k = 0; k < 4; k++) begin
      set_req(vecs[k].who, vecs[k].rd_wr_L, vecs[k].addr, vecs[k].q_addr, vecs[k].wr_data);
      serve($sformatf("vec%0d", k), vecs[k].exp_src, vecs[k].dly, vecs[k].res, 1);
      check($sformatf("vec%0d acc_rd_wr_L", k), acc_rd_wr_L, vecs[k].rd_wr_L);
      check($sformatf("vec%0d acc_addr", k), acc_addr, vecs[k].addr);
      check($sformatf("vec%0d acc_q_addr", k), acc_q_addr, vecs[k].q_addr);
      check($sformatf("vec%0d acc_wr_data", k), acc_wr_data, vecs[k].wr_data);
      step();
      check($sformatf("vec%0d no regrant", k), acc_valid, 0);
    end

    // Async reset in the middle of WAIT.
    set_req(1, 1'b0, 5'd7, 3'd2, 32'h5555_aaaa);
    step();
    step();
    step();
    reset = 0;
    acc_done = 1;
    acc_result = 32'h7777_7777;
    #1;
    check("rst acc_src", acc_src, 0);
    check("rst acc_addr", acc_addr, 0);
    check("rst acc_wr_data", acc_wr_data, 0);
    check("rst result", result, 0);
    step();
    check("rst dones", dones, 0);
    reset = 1;
    acc_done = 0;
    drop_req(1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst release no done", dones, 0);
      check("rst release no access", acc_valid, 0);
    end

    // Three simultaneous requests from reset: host, src, dst.
    do_reset();
    set_req(0, 1'b1, 5'd1, 3'd1, 32'h0);
    set_req(1, 1'b1, 5'd2, 3'd2, 32'h0);
    set_req(2, 1'b1, 5'd3, 3'd3, 32'h0);
    serve("sim host", 0, 1, 32'h0000_0101, 1);
    serve("sim src", 1, 1, 32'h0000_0202, 1);
    check("sim src acc_addr", acc_addr, 5'd2);
    serve("sim dst", 2, 2, 32'h0000_0303, 1);
    check("sim dst acc_q_addr", acc_q_addr, 3'd3);
    step();
    check("sim idle after", acc_valid, 0);

    // src held, dst requests once.
    do_reset();
    set_req(1, 1'b1, 5'd4, 3'd4, 32'h0);
    set_req(2, 1'b0, 5'd6, 3'd6, 32'h1111_2222);
    serve("alt src1", 1, 1, 32'h0000_0a01, 0);
    serve("alt dst", 2, 1, 32'h0000_0a02, 1);
    serve("alt src2", 1, 1, 32'h0000_0a03, 1);

    // acc_done outside WAIT is ignored.
    set_req(0, 1'b1, 5'd9, 3'd1, 32'h0);
    step();
    check("ign acc_valid", acc_valid, 1);
    acc_done = 1;
    acc_result = 32'hbad0_0001;
    step();
    acc_done = 0;
    step();
    check("ign issue done", dones, 0);
    step();
    check("ign still waiting", dones, 0);
    acc_done = 1;
    acc_result = 32'h600d_0001;
    step();
    check("ign host_done", dones, 3'b001);
    check("ign result", result, 32'h600d_0001);
    acc_result = 32'hbad0_0002;
    drop_req(0);
    step();
    check("ign done-state done", dones, 0);
    check("ign result held", result, 32'h600d_0001);
    step();
    check("ign idle done", dones, 0);
    check("ign idle access", acc_valid, 0);
    acc_done = 0;

    // Watchdog.
    do_reset();
    set_req(2, 1'b1, 5'd12, 3'd4, 32'h0);
    step();
    check("tmo acc_valid", acc_valid, 1);
`ifdef OQ_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      check("tmo waiting", dones, 0);
      check("tmo err low", timeout_err, 0);
    end
    step();
    check("tmo dst_done", dones, 3'b100);
    check("tmo timeout_err", timeout_err, 1);
    check("tmo result", result, 32'hdead_beef);
    drop_req(2);
    acc_done = 1;
    acc_result = 32'h0bad_0bad;
    step();
    check("tmo late done ignored", dones, 0);
    check("tmo err one cycle", timeout_err, 0);
    step();
    check("tmo late result", result, 32'hdead_beef);
    acc_done = 0;
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check("nowdg waiting", dones, 0);
      check("nowdg err low", timeout_err, 0);
    end
    acc_done = 1;
    acc_result = 32'h0000_5a5a;
    step();
    acc_done = 0;
    check("nowdg dst_done", dones, 3'b100);
    check("nowdg result", result, 32'h0000_5a5a);
    check("nowdg err", timeout_err, 0);
    drop_req(2);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
